// File: rtl/wrr_burst_arbiter_if.sv
// Request/grant bundle between the requesters and wrr_burst_arbiter.
// The lock signal exists only when WRR_LOCK_EN is defined.
interface wrr_burst_arbiter_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned WW = 4,
    parameter int unsigned IW = 2
);
    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic            ready;
    logic [N-1:0]    gnt;
    logic [IW-1:0]   gnt_id;
    logic            gnt_vld;
    logic            last;
`ifdef WRR_LOCK_EN
    logic            lock;

    modport master (input req, weight, ready, lock, output gnt, gnt_id, gnt_vld, last);
    modport slave  (output req, weight, ready, lock, input gnt, gnt_id, gnt_vld, last);
`else
    modport master (input req, weight, ready, output gnt, gnt_id, gnt_vld, last);
    modport slave  (output req, weight, ready, input gnt, gnt_id, gnt_vld, last);
`endif
endinterface

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter: a grant is held for up to weight[k] beats, then rotates.
// Optional feature macro WRR_LOCK_EN: lock input suppresses credit-expiry release.
module wrr_burst_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned WW = 4,
    parameter int unsigned IW = 2
) (
    input  logic                clk,
    input  logic                rst,
    wrr_burst_arbiter_if.master arb_if
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [WW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   credit_q, credit_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic            gnt_vld_q, gnt_vld_d;

    logic            pick_vld_c;
    logic [IW-1:0]   pick_id_c;
    logic [IW-1:0]   scan_idx_c;
    logic [WW-1:0]   pick_w_c;
    logic            beat_c;
    logic            at_end_c;
    logic            hold_c;
    logic            last_c;

    // First requester at or after ptr, wrapping N-1 -> 0
    always_comb begin
        pick_vld_c = 1'b0;
        pick_id_c  = '0;
        scan_idx_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            scan_idx_c = IW'((32'(ptr_q) + i) % N);
            if (!pick_vld_c && arb_if.req[scan_idx_c]) begin
                pick_vld_c = 1'b1;
                pick_id_c  = scan_idx_c;
            end
        end
        pick_w_c = arb_if.weight[pick_id_c*WW +: WW];
    end

`ifdef WRR_LOCK_EN
    assign hold_c = arb_if.lock;
`else
    assign hold_c = 1'b0;
`endif

    assign beat_c   = gnt_vld_q & arb_if.ready & arb_if.req[gnt_id_q];
    assign at_end_c = (cnt_q == (credit_q - WW'(1)));
    assign last_c   = beat_c & at_end_c & ~hold_c;

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        credit_d  = credit_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld_c) begin
                    state_d   = ST_GRANT;
                    gnt_d     = N'(1) << pick_id_c;
                    gnt_id_d  = pick_id_c;
                    gnt_vld_d = 1'b1;
                    credit_d  = (pick_w_c == '0) ? WW'(1) : pick_w_c;
                    cnt_d     = '0;
                end
            end
            ST_GRANT: begin
                // A dropped request or the final credited beat ends the burst
                if (!arb_if.req[gnt_id_q] || last_c) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    ptr_d     = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + IW'(1);
                end else if (beat_c && !at_end_c) begin
                    cnt_d = cnt_q + WW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            credit_q  <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            credit_q  <= credit_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

    assign arb_if.gnt     = gnt_q;
    assign arb_if.gnt_id  = gnt_id_q;
    assign arb_if.gnt_vld = gnt_vld_q;
    assign arb_if.last    = last_c;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Randomized bench for wrr_burst_arbiter against a grant/remaining-beats reference model.
// Build with WRR_LOCK_EN defined to exercise the lock input as well.
module tb_wrr_burst_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned WW = 4;
    localparam int unsigned IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wrr_burst_arbiter_if #(.N(N), .WW(WW), .IW(IW)) bus_if ();

    wrr_burst_arbiter #(.N(N), .WW(WW), .IW(IW)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: who owns the resource and how many credited beats remain
    bit m_granted;
    int m_owner;
    int m_left;
    int m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit lock_now();
`ifdef WRR_LOCK_EN
        return bus_if.lock;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int credit_of(input int p);
        int w;
        w = int'(bus_if.weight[p*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic bit exp_last();
        return m_granted && bus_if.ready && bus_if.req[m_owner] && (m_left == 1) && !lock_now();
    endfunction

    task automatic model_release();
        m_granted = 1'b0;
        m_ptr     = (m_owner + 1) % N;
    endtask

    task automatic model_edge();
        if (rst) begin
            m_granted = 1'b0;
            m_owner   = 0;
            m_left    = 0;
            m_ptr     = 0;
        end else if (!m_granted) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (bus_if.req[k]) begin
                    m_granted = 1'b1;
                    m_owner   = k;
                    m_left    = credit_of(k);
                    break;
                end
            end
        end else if (!bus_if.req[m_owner]) begin
            model_release();
        end else if (bus_if.ready) begin
            if (m_left == 1) begin
                if (!lock_now()) model_release();
            end else begin
                m_left--;
            end
        end
    endtask

    // One clock: check combinational last before the edge, registered outputs after it
    task automatic step();
        logic [N-1:0] exp_gnt;
        @(negedge clk);
        check_eq("last", 32'(bus_if.last), 32'(exp_last()));
        @(posedge clk);
        model_edge();
        #1;
        exp_gnt = m_granted ? (N'(1) << m_owner) : '0;
        check_eq("gnt", 32'(bus_if.gnt), 32'(exp_gnt));
        check_eq("gnt_vld", 32'(bus_if.gnt_vld), 32'(m_granted));
        check_eq("gnt_id", 32'(bus_if.gnt_id), 32'(m_owner));
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    task automatic randomize_inputs();
        for (int p = 0; p < N; p++)
            if ($urandom_range(7, 0) == 0) bus_if.req[p] = ~bus_if.req[p];
        bus_if.ready = ($urandom_range(3, 0) != 0);
        if ($urandom_range(15, 0) == 0)
            bus_if.weight[$urandom_range(N - 1, 0)*WW +: WW] = WW'($urandom_range(15, 0));
        rst = ($urandom_range(149, 0) == 0);
`ifdef WRR_LOCK_EN
        if ($urandom_range(5, 0) == 0) bus_if.lock = ~bus_if.lock;
`endif
    endtask

    initial begin
        m_granted     = 1'b0;
        m_owner       = 0;
        m_left        = 0;
        m_ptr         = 0;
        rst           = 1'b1;
        bus_if.req    = 4'b1111;
        bus_if.weight = {4'd1, 4'd2, 4'd3, 4'd4};
        bus_if.ready  = 1'b1;
`ifdef WRR_LOCK_EN
        bus_if.lock   = 1'b0;
`endif
        // Reset with all requests pending, then the weighted rotation
        run(2);
        rst = 1'b0;
        step();
        check_eq("first_grant", 32'(bus_if.gnt), 32'd1);
        run(24);

        // Zero weight acts as one; stall mid-grant
        bus_if.req    = 4'b0001;
        bus_if.weight = {4'd1, 4'd2, 4'd3, 4'd0};
        run(8);
        bus_if.ready = 1'b0;
        run(3);
        bus_if.ready = 1'b1;
        run(4);

        // Reset in the middle of a 4-beat burst
        bus_if.req    = 4'b1111;
        bus_if.weight = {4'd4, 4'd4, 4'd4, 4'd4};
        run(3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(6);

        // Request dropped mid-burst
        bus_if.weight = {4'd5, 4'd5, 4'd5, 4'd5};
        run(3);
        bus_if.req[m_owner] = 1'b0;
        run(4);

`ifdef WRR_LOCK_EN
        // Lock holds port 2 past its credit until lock falls
        bus_if.req    = 4'b0100;
        bus_if.weight = {4'd1, 4'd2, 4'd1, 4'd1};
        bus_if.lock   = 1'b1;
        run(7);
        bus_if.lock = 1'b0;
        run(4);
`endif

        for (int c = 0; c < 3000; c++) begin
            randomize_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
